// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
// DEMUX_SKID_EN selects 2-entry port slots; the default build uses 1-entry slots.
package demux_pkg;

  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

`ifdef DEMUX_SKID_EN
  localparam int SLOT_DEPTH = 2;
`else
  localparam int SLOT_DEPTH = 1;
`endif

endpackage

// File: rtl/demux_out_slot.sv
// Per-port output slot: 1 entry by default, 2-entry FIFO when DEMUX_SKID_EN is defined.
// The head entry drives the port directly, so data leaves straight from a register.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic [size-1:0] push_data,
  output logic            can_push,
  output logic            valid,
  input  logic            ready,
  output logic [size-1:0] data
);

  localparam logic [1:0] FULL_COUNT = 2'(SLOT_DEPTH);

  logic [1:0]      count;
  logic [size-1:0] head;
  logic            full;
  logic            do_push;
  logic            do_pop;
  logic            refill;
  logic [size-1:0] refill_data;

  assign full   = (count == FULL_COUNT);
  assign valid  = (count != 2'd0);
  assign data   = head;
  assign do_pop = valid & ready;

`ifdef DEMUX_SKID_EN
  // A full FIFO refuses a push even if it pops this edge, keeping can_push register-only.
  assign can_push = !full;
`else
  assign can_push = !full | do_pop;
`endif

  assign do_push = push & can_push;

`ifdef DEMUX_SKID_EN
  logic [size-1:0] tail;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tail <= '0;
    end else if (do_push && !do_pop && (count == 2'd1)) begin
      tail <= push_data;
    end
  end

  assign refill      = do_pop && (count == 2'd2);
  assign refill_data = tail;
`else
  assign refill      = 1'b0;
  assign refill_data = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= 2'd0;
      head  <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // New word becomes head only if the slot was empty or its sole entry leaves now.
      if (refill) begin
        head <= refill_data;
      end else if (do_push && ((count == 2'd0) || do_pop)) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/demux_1to2_buf.sv
// Registered 1-to-2 valid/ready demultiplexer; select_i steers each word to one port slot.
// Optional macro DEMUX_SKID_EN gives each port a 2-entry slot and a register-only ready_o.
module demux_1to2_buf
  import demux_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  output logic            valid0_o,
  input  logic            ready0_i,
  output logic [size-1:0] data0_o,
  output logic            valid1_o,
  input  logic            ready1_i,
  output logic [size-1:0] data1_o
);

  logic can_push0;
  logic can_push1;
  logic push0;
  logic push1;
  logic accept;

  assign ready_o = !rst_i && ((select_i == SEL_PORT1) ? can_push1 : can_push0);
  assign accept  = valid_i & ready_o;
  assign push0   = accept & (select_i == SEL_PORT0);
  assign push1   = accept & (select_i == SEL_PORT1);

  demux_out_slot #(.size(size)) u_slot0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push0),
    .push_data (data_i),
    .can_push  (can_push0),
    .valid     (valid0_o),
    .ready     (ready0_i),
    .data      (data0_o)
  );

  demux_out_slot #(.size(size)) u_slot1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push1),
    .push_data (data_i),
    .can_push  (can_push1),
    .valid     (valid1_o),
    .ready     (ready1_i),
    .data      (data1_o)
  );

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Directed self-checking bench for demux_1to2_buf (either slot depth).
module tb_demux_1to2_buf;

`ifdef DEMUX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        select_i;
  logic        valid0_o;
  logic        ready0_i;
  logic [31:0] data0_o;
  logic        valid1_o;
  logic        ready1_i;
  logic [31:0] data1_o;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1to2_buf #(.size(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .select_i (select_i),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data0_o  (data0_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .data1_o  (data1_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i    = 1'b1;
    valid_i  = 1'b1;
    select_i = 1'b0;
    data_i   = 32'h77;
    ready0_i = 1'b1;
    ready1_i = 1'b1;

    // reset held with a valid producer word
    repeat (2) cyc();
    chk("rst_ready", ready_o, 0);
    chk("rst_valid0", valid0_o, 0);
    chk("rst_valid1", valid1_o, 0);
    chk("rst_data0", data0_o, 0);
    chk("rst_data1", data1_o, 0);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("post_rst_ready", ready_o, 1);

    // steering
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'hA5;
    cyc();
    chk("steer_v0", valid0_o, 1);
    chk("steer_d0", data0_o, 32'hA5);
    chk("steer_v1_idle", valid1_o, 0);
    select_i = 1'b1; data_i = 32'h5A;
    cyc();
    valid_i = 1'b0;
    chk("steer_v1", valid1_o, 1);
    chk("steer_d1", data1_o, 32'h5A);
    chk("steer_v0_idle", valid0_o, 0);
    cyc();
    chk("steer_drain", valid1_o, 0);

    // isolation: port 0 stalled, port 1 still flows
    ready0_i = 1'b0;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'h11;
    cyc();
    valid_i = 1'b0;
    chk("iso_v0", valid0_o, 1);
    chk("iso_d0", data0_o, 32'h11);
    valid_i = 1'b1; select_i = 1'b1; data_i = 32'h22;
    #1;
    chk("iso_ready_p1", ready_o, 1);
    cyc();
    valid_i = 1'b0;
    chk("iso_v1", valid1_o, 1);
    chk("iso_d1", data1_o, 32'h22);
    chk("iso_v0_hold", valid0_o, 1);
    chk("iso_d0_hold", data0_o, 32'h11);
    cyc();
    chk("iso_v1_gone", valid1_o, 0);
    chk("iso_d0_stable", data0_o, 32'h11);
    ready0_i = 1'b1;
    cyc();
    chk("iso_v0_gone", valid0_o, 0);

    // back-pressure limit on port 0
    ready0_i = 1'b0;
    valid_i  = 1'b1; select_i = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      data_i = 32'(i + 1);
      #1;
      chk("bp_ready", ready_o, (i < DEPTH) ? 1 : 0);
      if (i < DEPTH) cyc();
    end
    valid_i  = 1'b0;
    ready0_i = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      chk("bp_v0", valid0_o, 1);
      chk("bp_order", data0_o, 64'(k));
      cyc();
    end
    chk("bp_empty", valid0_o, 0);

    // streaming, alternating select
    for (int i = 0; i < 100; i++) begin
      valid_i = 1'b1; select_i = i[0]; data_i = 32'h100 + 32'(i);
      #1;
      chk("stream_ready", ready_o, 1);
      cyc();
      chk("stream_valid", i[0] ? valid1_o : valid0_o, 1);
      chk("stream_data", i[0] ? data1_o : data0_o, 32'h100 + 32'(i));
      chk("stream_other", i[0] ? valid0_o : valid1_o, 0);
    end
    valid_i = 1'b0;
    cyc();
    chk("stream_end_v0", valid0_o, 0);
    chk("stream_end_v1", valid1_o, 0);

    // mid-stream reset with both slots occupied
    ready0_i = 1'b0; ready1_i = 1'b0;
    valid_i = 1'b1; select_i = 1'b0; data_i = 32'hC0;
    cyc();
    select_i = 1'b1; data_i = 32'hC1;
    cyc();
    valid_i = 1'b0;
    chk("mrst_pre_v0", valid0_o, 1);
    chk("mrst_pre_v1", valid1_o, 1);
    rst_i = 1'b1; ready0_i = 1'b1; ready1_i = 1'b1;
    #1;
    chk("mrst_ready", ready_o, 0);
    cyc();
    chk("mrst_v0", valid0_o, 0);
    chk("mrst_v1", valid1_o, 0);
    chk("mrst_d0", data0_o, 0);
    chk("mrst_d1", data1_o, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mrst_after_v0", valid0_o, 0);
      chk("mrst_after_v1", valid1_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
